// File: rtl/cpu_pkg.sv
// Shared CPU constants, selection encoding and register-mask helpers
// used by the writeback arbiter and its load buffer.
package cpu_pkg;

    localparam int CPU_XLEN     = 32;
    localparam int REG_AW       = 5;
    localparam int NUM_REGS     = 1 << REG_AW;
    localparam int LB_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_LB
    } wb_sel_e;

    // One-hot mask for a destination register; x0 never maps to a bit.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_AW-1:0] rd);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (rd != '0) begin
            m[rd] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic reg_writes(input logic [REG_AW-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU and load result handshakes, load-issue marking,
// scoreboard queries and the register-file write port.
interface wb_arbiter_if #(
    parameter int XLEN = cpu_pkg::CPU_XLEN
);
    import cpu_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [REG_AW-1:0] lsu_rd;
    logic [XLEN-1:0]   lsu_data;

    logic              iss_valid;
    logic [REG_AW-1:0] iss_rd;

    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;

    logic              rd_we;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rd_wdata;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_rd,
        input  rs1_addr, rs2_addr,
        output alu_ready, lsu_ready,
        output rs1_busy, rs2_busy,
        output rd_we, rd_addr, rd_wdata
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_rd,
        output rs1_addr, rs2_addr,
        input  alu_ready, lsu_ready,
        input  rs1_busy, rs2_busy,
        input  rd_we, rd_addr, rd_wdata
    );

endinterface

// File: rtl/wb_fifo.sv
// Load-result buffer: power-of-two FIFO with wrapping pointers and a
// count one bit wider than the pointers so full and empty stay distinct.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_data_o = mem_q[rptr_q];

    // A pop in the same cycle frees the slot, so a push is legal even when full.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load results onto the
// single register-file write port and tracks pending loads in a scoreboard.
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int XLEN     = CPU_XLEN,
    parameter int LB_DEPTH = LB_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int EW = REG_AW + XLEN;

    logic                lb_push;
    logic                lb_pop;
    logic                lb_full;
    logic                lb_empty;
    logic [EW-1:0]       lb_head;
    logic [REG_AW-1:0]   head_rd;
    logic [XLEN-1:0]     head_data;

    wb_sel_e             sel;
    logic [REG_AW-1:0]   sel_rd;
    logic [XLEN-1:0]     sel_data;

    logic                rd_we_q, rd_we_d;
    logic [REG_AW-1:0]   rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]     rd_wdata_q, rd_wdata_d;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_mask, clr_mask;

    wb_fifo #(
        .WIDTH (EW),
        .DEPTH (LB_DEPTH)
    ) u_lb (
        .clk         (clk),
        .rst         (rst),
        .push_i      (lb_push),
        .push_data_i ({bus.lsu_rd, bus.lsu_data}),
        .pop_i       (lb_pop),
        .pop_data_o  (lb_head),
        .full_o      (lb_full),
        .empty_o     (lb_empty)
    );

    assign head_rd   = lb_head[XLEN +: REG_AW];
    assign head_data = lb_head[XLEN-1:0];

    assign bus.lsu_ready = !lb_full;
    assign bus.alu_ready = !lb_full;
    assign lb_push       = bus.lsu_valid && !lb_full;

    // A full buffer must drain before the ALU may use the port again.
    always_comb begin
        sel = SEL_NONE;
        if (lb_full) begin
            sel = SEL_LB;
        end else if (bus.alu_valid) begin
            sel = SEL_ALU;
        end else if (!lb_empty) begin
            sel = SEL_LB;
        end
    end

    assign lb_pop = (sel == SEL_LB);

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        case (sel)
            SEL_ALU: begin
                sel_rd   = bus.alu_rd;
                sel_data = bus.alu_data;
            end
            SEL_LB: begin
                sel_rd   = head_rd;
                sel_data = head_data;
            end
            default: begin
                sel_rd   = '0;
                sel_data = '0;
            end
        endcase
    end

    // Address and data hold between writes; only the enable pulses.
    always_comb begin
        rd_we_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_wdata_d = rd_wdata_q;
        if (sel != SEL_NONE) begin
            rd_we_d    = reg_writes(sel_rd);
            rd_addr_d  = sel_rd;
            rd_wdata_d = sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_we_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_wdata_q <= '0;
        end else begin
            rd_we_q    <= rd_we_d;
            rd_addr_q  <= rd_addr_d;
            rd_wdata_q <= rd_wdata_d;
        end
    end

    assign bus.rd_we    = rd_we_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_wdata = rd_wdata_q;

    // A new issue to a register wins over the pop of its previous load.
    assign set_mask = bus.iss_valid ? reg_mask(bus.iss_rd) : '0;
    assign clr_mask = lb_pop ? reg_mask(head_rd) : '0;
    assign busy_d   = (busy_q & ~clr_mask) | set_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.rs1_busy = (bus.rs1_addr != '0) && busy_q[bus.rs1_addr];
    assign bus.rs2_busy = (bus.rs2_addr != '0) && busy_q[bus.rs2_addr];

endmodule
